// File: rtl/wb_load_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_load_unit_if
//  Description : Memory response channel between the data bus and the
//                write-back load unit. The bus side drives the beat
//                (master); the load unit accepts it (slave).
//  Signals     : resp_valid - response beat valid        (master -> slave)
//                resp_data  - response data, XLEN bits    (master -> slave)
//                resp_err   - bus error, qualified by valid (master -> slave)
//                resp_ready - slave can accept a beat     (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_load_unit_if #(
    parameter int XLEN = 32
);
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic            resp_err;

    modport master (
        output resp_valid,
        output resp_data,
        output resp_err,
        input  resp_ready
    );

    modport slave (
        input  resp_valid,
        input  resp_data,
        input  resp_err,
        output resp_ready
    );
endinterface
`default_nettype wire

// File: rtl/wb_load_unit.sv
`default_nettype none
// ============================================================================
//  Module      : wb_load_unit
//  Description : Write-back stage load unit. Holds one instruction in a
//                stage register, buffers memory responses in a small FIFO
//                (with a same-cycle bypass when the FIFO is empty), extracts
//                and extends the addressed load field and drives the
//                register-file write port.
//  Ports       : clk, rstn (async, active-low)
//                in_valid/in_rd/in_rf_we/in_is_load/in_byte_sel/
//                in_addr_off/in_dout - upstream instruction
//                stall               - hold the stage register
//                resp                - memory response channel (slave)
//                hazard              - load in stage is waiting for data
//                rf_wren/rf_waddr/rf_wdata - register-file write port
//                load_err            - one-cycle error pulse for a load
//                fifo_cnt            - response FIFO occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_load_unit #(
    parameter  int XLEN       = 32,
    parameter  int RESP_DEPTH = 2,
    localparam int OFFW       = $clog2(XLEN / 8),
    localparam int CNTW       = $clog2(RESP_DEPTH) + 1
) (
    input  wire logic              clk,
    input  wire logic              rstn,

    input  wire logic              in_valid,
    input  wire logic [4:0]        in_rd,
    input  wire logic              in_rf_we,
    input  wire logic              in_is_load,
    input  wire logic [2:0]        in_byte_sel,
    input  wire logic [OFFW-1:0]   in_addr_off,
    input  wire logic [XLEN-1:0]   in_dout,
    input  wire logic              stall,

    wb_load_unit_if.slave          resp,

    output logic                   hazard,
    output logic                   rf_wren,
    output logic [4:0]             rf_waddr,
    output logic [XLEN-1:0]        rf_wdata,
    output logic                   load_err,
    output logic [CNTW-1:0]        fifo_cnt
);

    localparam int PTRW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    // ------------------------------------------------------------------
    // Stage register
    // ------------------------------------------------------------------
    logic              valid_q;
    logic [4:0]        rd_q;
    logic              rf_we_q;
    logic              is_load_q;
    logic [2:0]        byte_sel_q;
    logic [OFFW-1:0]   addr_off_q;
    logic [XLEN-1:0]   dout_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q    <= 1'b0;
            rd_q       <= '0;
            rf_we_q    <= 1'b0;
            is_load_q  <= 1'b0;
            byte_sel_q <= '0;
            addr_off_q <= '0;
            dout_q     <= '0;
        end else if (!stall) begin
            valid_q    <= in_valid;
            rd_q       <= in_rd;
            rf_we_q    <= in_rf_we;
            is_load_q  <= in_is_load;
            byte_sel_q <= in_byte_sel;
            addr_off_q <= in_addr_off;
            dout_q     <= in_dout;
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO: {data, err} entries, wrapping pointers plus count
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   fifo_data_q [RESP_DEPTH];
    logic              fifo_err_q  [RESP_DEPTH];
    logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]   cnt_q,    cnt_d;

    logic              w_empty;
    logic              w_data_avail;
    logic [XLEN-1:0]   w_src_data;
    logic              w_src_err;
    logic              w_consume;
    logic              w_push;
    logic              w_pop;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_empty         = (cnt_q == '0);
    // Readiness depends only on stored occupancy; a pop in the same cycle
    // does not free a slot until the next cycle.
    assign resp.resp_ready = (cnt_q < CNTW'(RESP_DEPTH));

    // With an empty FIFO the incoming beat is forwarded straight to the
    // stage so a load can retire in the cycle its response arrives.
    assign w_data_avail = !w_empty || resp.resp_valid;
    assign w_src_data   = w_empty ? resp.resp_data : fifo_data_q[rd_ptr_q];
    assign w_src_err    = w_empty ? resp.resp_err  : fifo_err_q[rd_ptr_q];

    assign hazard    = valid_q && is_load_q && !w_data_avail;
    assign w_consume = valid_q && is_load_q && w_data_avail && !stall;
    assign w_pop     = w_consume && !w_empty;
    // A bypassed beat that is consumed immediately is not stored.
    assign w_push    = resp.resp_valid && resp.resp_ready
                       && !(w_empty && w_consume);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (w_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (w_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + CNTW'(1);
            2'b01:   cnt_d = cnt_q - CNTW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage needs no reset: a cleared count makes old entries
    // unreachable.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_data_q[wr_ptr_q] <= resp.resp_data;
            fifo_err_q[wr_ptr_q]  <= resp.resp_err;
        end
    end

    assign fifo_cnt = cnt_q;

    // ------------------------------------------------------------------
    // Load field extraction and extension
    // ------------------------------------------------------------------
    logic [OFFW-1:0]   w_off_al;
    logic [OFFW+2:0]   w_shamt;
    logic [XLEN-1:0]   w_shifted;
    logic [XLEN-1:0]   w_word_s;
    logic [XLEN-1:0]   w_word_u;
    logic [XLEN-1:0]   w_load_data;

    // Align the offset to the access size: halves drop bit 0, words drop
    // bits [1:0], full-width accesses always start at byte 0.
    always_comb begin
        w_off_al = addr_off_q;
        case (byte_sel_q[1:0])
            2'd0:    w_off_al = addr_off_q;
            2'd1:    w_off_al = addr_off_q & ~OFFW'(1);
            2'd2:    w_off_al = addr_off_q & ~OFFW'(3);
            default: w_off_al = '0;
        endcase
    end

    assign w_shamt   = {w_off_al, 3'b000};
    assign w_shifted = w_src_data >> w_shamt;

    generate
        if (XLEN == 32) begin : g_word_full
            // A word is the whole register: LW/LWU return it unchanged.
            assign w_word_s = w_shifted;
            assign w_word_u = w_shifted;
        end else begin : g_word_ext
            assign w_word_s = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
            assign w_word_u = {{(XLEN-32){1'b0}},          w_shifted[31:0]};
        end
    endgenerate

    always_comb begin
        w_load_data = w_src_data;
        case (byte_sel_q)
            3'd0:    w_load_data = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
            3'd1:    w_load_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            3'd2:    w_load_data = w_word_s;
            3'd4:    w_load_data = {{(XLEN-8){1'b0}},           w_shifted[7:0]};
            3'd5:    w_load_data = {{(XLEN-16){1'b0}},          w_shifted[15:0]};
            3'd6:    w_load_data = w_word_u;
            default: w_load_data = w_src_data;
        endcase
    end

    // ------------------------------------------------------------------
    // Register-file write port
    // ------------------------------------------------------------------
    assign rf_waddr = rd_q;
    assign rf_wdata = is_load_q ? w_load_data : dout_q;
    // Loads write only with error-free data in hand; x0 is never written.
    assign rf_wren  = valid_q && rf_we_q && !stall
                      && !(is_load_q && (!w_data_avail || w_src_err))
                      && (rd_q != 5'd0);
    assign load_err = w_consume && w_src_err;

endmodule
`default_nettype wire
